// File: rtl/serial_adder_pkg.sv
// Shared constants for the serial adder tile: state encoding, operand width, pin bit positions.
package serial_adder_pkg;

  localparam int WIDTH = 4;
  localparam int CNT_W = $clog2(WIDTH);

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // uo_out packing
  localparam int SUM_LSB  = 0;
  localparam int COUT_BIT = 4;
  localparam int BUSY_BIT = 5;
  localparam int DONE_BIT = 6;
  localparam int OVF_BIT  = 7;

  // uio_in packing
  localparam int START_BIT = 0;
  localparam int SUB_BIT   = 1;

endpackage

// File: rtl/full_adder_bit.sv
// Single combinational full-adder cell, time-shared across all operand bits by the controller.
// Zero latency, no flow control.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/tt_um_serial_adder_ctrl.sv
// Bit-serial WIDTH-bit add/subtract, LSB first; result and flags appear WIDTH+1 edges after start.
// No backpressure: start is ignored while busy, and ena=0 freezes all state in place.
module tt_um_serial_adder_ctrl
  import serial_adder_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   res_sr;
  logic               carry;
  logic               sub_q;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic               ovf;

  logic               fa_s;
  logic               fa_cout;
  logic [WIDTH-1:0]   res_next;

  logic start;
  logic sub;
  assign start = uio_in[START_BIT];
  assign sub   = uio_in[SUB_BIT];

  full_adder_bit u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign res_next = {fa_s, res_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      sub_q  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (ena) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr  <= ui_in[WIDTH-1:0];
            // Subtraction is a + ~b + 1: invert b here, inject the +1 as carry-in.
            b_sr  <= sub ? ~ui_in[2*WIDTH-1:WIDTH] : ui_in[2*WIDTH-1:WIDTH];
            carry <= sub;
            sub_q <= sub;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next;
          carry  <= fa_cout;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            sum   <= res_next;
            cout  <= fa_cout;
            // carry still holds the carry into the MSB on this edge
            ovf   <= carry ^ fa_cout;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!start) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    uo_out                     = '0;
    uo_out[SUM_LSB +: WIDTH]   = sum;
    uo_out[COUT_BIT]           = cout;
    uo_out[BUSY_BIT]           = (state == ST_RUN);
    uo_out[DONE_BIT]           = (state == ST_DONE);
    uo_out[OVF_BIT]            = ovf;
  end

  assign uio_out = '0;
  assign uio_oe  = '0;

  wire _unused = &{1'b0, uio_in[7:2], sub_q};

endmodule

// File: tb/tb_tt_um_serial_adder_ctrl.sv
// Directed self-checking bench for the serial adder tile.
module tb_tt_um_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;
  logic [3:0] last_sum = 4'h0;

  tt_um_serial_adder_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one op with a single-cycle start pulse and check latency, flags and hold-back of partial bits.
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b, input logic sub,
                        input logic [3:0] es, input logic ec, input logic eo);
    int lat;
    bit seen;
    ui_in  = {b, a};
    uio_in = {6'b0, sub, 1'b1};
    step();
    uio_in[0] = 1'b0;
    check({tag, " busy_after_launch"}, uo_out[5], 1'b1);
    lat  = 0;
    seen = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      step();
      if (uo_out[6]) begin
        seen = 1;
        lat  = i;
      end else begin
        check({tag, " sum_held_midrun"}, uo_out[3:0], last_sum);
      end
    end
    check({tag, " latency"}, lat, 4);
    check({tag, " sum"}, uo_out[3:0], es);
    check({tag, " cout"}, uo_out[4], ec);
    check({tag, " ovf"}, uo_out[7], eo);
    check({tag, " busy_in_done"}, uo_out[5], 1'b0);
    last_sum = es;
    step();
    check({tag, " done_cleared"}, uo_out[6], 1'b0);
    check({tag, " sum_kept_idle"}, uo_out[3:0], es);
    check({tag, " uio_tied"}, {uio_out, uio_oe}, 16'h0);
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    #1;
    check("reset_uo_out", uo_out, 8'h00);
    check("reset_uio", {uio_out, uio_oe}, 16'h0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("idle_after_reset", uo_out, 8'h00);

    run_op("add_3_5", 4'd3, 4'd5, 1'b0, 4'h8, 1'b0, 1'b1);

    // Async reset two edges into a run
    ui_in  = 8'h77;
    uio_in = 8'h01;
    step();
    uio_in = 8'h00;
    step();
    step();
    check("busy_before_reset", uo_out[5], 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_reset_midrun", uo_out, 8'h00);
    last_sum = 4'h0;
    step();
    rst_n = 1'b1;
    step();
    check("idle_after_midrun_reset", uo_out, 8'h00);
    run_op("add_1_1", 4'd1, 4'd1, 1'b0, 4'h2, 1'b0, 1'b0);

    run_op("add_15_1", 4'd15, 4'd1, 1'b0, 4'h0, 1'b1, 1'b0);
    run_op("sub_5_3", 4'd5, 4'd3, 1'b1, 4'h2, 1'b1, 1'b0);

    // Sub 3-5 with start held high well past completion
    ui_in  = 8'h53;
    uio_in = 8'h03;
    for (int i = 0; i < 5; i++) step();
    check("hold_done", uo_out[6], 1'b1);
    check("hold_sum", uo_out[3:0], 4'hE);
    check("hold_cout", uo_out[4], 1'b0);
    check("hold_ovf", uo_out[7], 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_no_relaunch", uo_out[6:5], 2'b10);
    end
    uio_in = 8'h00;
    step();
    check("hold_release_done", uo_out[6], 1'b0);
    check("hold_release_sum", uo_out[3:0], 4'hE);
    last_sum = 4'hE;

    // ena=0 for 3 cycles after E2: 2+3, outputs frozen at 0x2E (busy, prior sum E)
    ui_in  = 8'h32;
    uio_in = 8'h01;
    step();
    uio_in = 8'h00;
    step();
    step();
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ena_frozen", uo_out, 8'h2E);
    end
    ena = 1'b1;
    step();
    check("ena_resume_busy", uo_out, 8'h2E);
    step();
    check("ena_done", uo_out, 8'h45);
    step();
    check("ena_to_idle", uo_out, 8'h05);
    last_sum = 4'h5;

    // Inputs change mid-run: 1+2 launched, then a=7,b=7,sub=1 presented
    ui_in  = 8'h21;
    uio_in = 8'h01;
    step();
    ui_in  = 8'h77;
    uio_in = 8'h02;
    for (int i = 0; i < 4; i++) step();
    check("midrun_change_result", uo_out, 8'h43);
    check("midrun_uio", {uio_out, uio_oe}, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
